// File: rtl/lt24_pkg.sv
// lt24_pkg: shared LT24 panel geometry, colours, coordinate widths
// and renderer state encoding.
package lt24_pkg;

  localparam int X_W         = 8;
  localparam int Y_W         = 9;
  localparam int LT24_WIDTH  = 240;
  localparam int LT24_HEIGHT = 320;

  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB565_BLACK = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_ERASE = 3'b010,
    S_DRAW  = 3'b100
  } state_t;

endpackage

// File: rtl/sprite_scan_counter.sv
// sprite_scan_counter: row-major SIZE x SIZE scan over a base origin,
// with clipping against the panel edges and a last-pixel flag.
module sprite_scan_counter
  import lt24_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int WIDTH  = LT24_WIDTH,
  parameter int HEIGHT = LT24_HEIGHT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clear,
  input  logic           i_advance,
  input  logic [X_W-1:0] i_base_x,
  input  logic [Y_W-1:0] i_base_y,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_clipped,
  output logic           o_last
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] MAX = CW'(SIZE - 1);

  logic [CW-1:0] r_col;
  logic [CW-1:0] r_row;
  logic [X_W:0]  w_sum_x;
  logic [Y_W:0]  w_sum_y;

  // One extra bit so a square hanging off the edge never wraps to 0.
  assign w_sum_x = {1'b0, i_base_x} + (X_W+1)'(r_col);
  assign w_sum_y = {1'b0, i_base_y} + (Y_W+1)'(r_row);

  assign o_x       = w_sum_x[X_W-1:0];
  assign o_y       = w_sum_y[Y_W-1:0];
  assign o_clipped = (w_sum_x >= (X_W+1)'(WIDTH)) ||
                     (w_sum_y >= (Y_W+1)'(HEIGHT));
  assign o_last    = (r_col == MAX) && (r_row == MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_advance) begin
      if (r_col == MAX) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cursor_sprite_renderer.sv
// cursor_sprite_renderer: erases the cursor square at its old origin
// and redraws it at the new one through the LT24 pixel write port.
module cursor_sprite_renderer
  import lt24_pkg::*;
#(
  parameter int          SIZE      = 4,
  parameter int          WIDTH     = LT24_WIDTH,
  parameter int          HEIGHT    = LT24_HEIGHT,
  parameter logic [15:0] FG_COLOUR = RGB565_WHITE,
  parameter logic [15:0] BG_COLOUR = RGB565_BLACK
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [X_W-1:0] xorigin,
  input  logic [Y_W-1:0] yorigin,
  input  logic           pixelReady,
  output logic           pixelWrite,
  output logic [X_W-1:0] xAddr,
  output logic [Y_W-1:0] yAddr,
  output logic [15:0]    pixelData,
  output logic           busy
);

  state_t         r_state;
  logic [X_W-1:0] r_prev_x;
  logic [Y_W-1:0] r_prev_y;
  logic [X_W-1:0] r_tgt_x;
  logic [Y_W-1:0] r_tgt_y;
  logic           r_drawn;

  logic           w_busy;
  logic           w_clip;
  logic           w_last;
  logic           w_step;
  logic           w_clear;
  logic [X_W-1:0] w_base_x;
  logic [Y_W-1:0] w_base_y;

  assign w_busy   = (r_state != S_IDLE);
  assign w_step   = w_busy && (w_clip || pixelReady);
  assign w_clear  = !w_busy || (w_step && w_last);
  assign w_base_x = (r_state == S_ERASE) ? r_prev_x : r_tgt_x;
  assign w_base_y = (r_state == S_ERASE) ? r_prev_y : r_tgt_y;

  sprite_scan_counter #(
    .SIZE   (SIZE),
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_scan (
    .clk       (clock),
    .rst_n     (reset),
    .i_clear   (w_clear),
    .i_advance (w_step),
    .i_base_x  (w_base_x),
    .i_base_y  (w_base_y),
    .o_x       (xAddr),
    .o_y       (yAddr),
    .o_clipped (w_clip),
    .o_last    (w_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_prev_x <= '0;
      r_prev_y <= '0;
      r_tgt_x  <= '0;
      r_tgt_y  <= '0;
      r_drawn  <= 1'b0;
    end else begin
      unique case (1'b1)
        r_state[0]: begin
          if (!r_drawn || (xorigin != r_prev_x) ||
              (yorigin != r_prev_y)) begin
            r_tgt_x <= xorigin;
            r_tgt_y <= yorigin;
            r_state <= r_drawn ? S_ERASE : S_DRAW;
          end
        end
        r_state[1]: begin
          if (w_step && w_last) r_state <= S_DRAW;
        end
        r_state[2]: begin
          if (w_step && w_last) begin
            r_prev_x <= r_tgt_x;
            r_prev_y <= r_tgt_y;
            r_drawn  <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pixelWrite = w_busy && !w_clip;
  assign busy       = w_busy;
  assign pixelData  = (r_state == S_ERASE) ? BG_COLOUR :
                      (r_state == S_DRAW)  ? FG_COLOUR : 16'h0000;

endmodule

// File: tb/tb_cursor_sprite_renderer.sv
// tb_cursor_sprite_renderer: table-driven moves, stall/reset/mid-move
// sequences and randomized moves against a square-painting model.
module tb_cursor_sprite_renderer;

  localparam int SIZE = 4;
  localparam int W    = 240;
  localparam int H    = 320;
  localparam logic [15:0] FG = 16'hFFFF;
  localparam logic [15:0] BG = 16'h0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  xorigin = '0;
  logic [8:0]  yorigin = '0;
  logic        pixelReady = 1'b1;
  logic        pixelWrite;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic [15:0] pixelData;
  logic        busy;

  cursor_sprite_renderer dut (
    .clock      (clock),
    .reset      (reset),
    .xorigin    (xorigin),
    .yorigin    (yorigin),
    .pixelReady (pixelReady),
    .pixelWrite (pixelWrite),
    .xAddr      (xAddr),
    .yAddr      (yAddr),
    .pixelData  (pixelData),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  x;
    logic [8:0]  y;
    logic [15:0] d;
  } px_t;

  typedef struct {
    int x;
    int y;
    int fg;
    int bg;
    int cyc;
    int pw0;
  } vec_t;

  px_t got_q[$];
  px_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  m_x = 0;
  int  m_y = 0;
  bit  m_drawn = 0;
  bit  rand_ready = 0;
  bit  s_pend = 0;
  px_t s_px;

  task automatic check(input string name, input longint got,
                       input longint req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Transfer monitor plus stall-hold check, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset && s_pend)
      check("stall_hold", {pixelWrite, xAddr, yAddr, pixelData},
            {1'b1, s_px});
    s_pend = reset && pixelWrite && !pixelReady;
    s_px   = px_t'{xAddr, yAddr, pixelData};
    if (reset && pixelWrite && pixelReady)
      got_q.push_back(px_t'{xAddr, yAddr, pixelData});
  end

  always @(posedge clock) begin
    if (rand_ready) begin
      #1;
      pixelReady = 1'($urandom_range(0, 1));
    end
  end

  task automatic model_square(input int bx, input int by,
                              input logic [15:0] c);
    for (int r = 0; r < SIZE; r++)
      for (int k = 0; k < SIZE; k++)
        if (bx + k < W && by + r < H)
          exp_q.push_back(px_t'{8'(bx + k), 9'(by + r), c});
  endtask

  task automatic model_move(input int x, input int y);
    if (m_drawn) model_square(m_x, m_y, BG);
    model_square(x, y, FG);
    m_x = x;
    m_y = y;
    m_drawn = 1;
  endtask

  function automatic int count_col(input logic [15:0] c);
    int n = 0;
    foreach (got_q[i]) if (got_q[i].d == c) n++;
    return n;
  endfunction

  task automatic check_seq(input string name);
    int bad = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    if (bad < 0 && got_q.size() != exp_q.size())
      bad = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s: %0d writes, required %0d, first difference at write %0d",
               name, got_q.size(), exp_q.size(), bad);
    end
  endtask

  task automatic wait_busy(output int lat, output int cyc, output bit pw0);
    lat = 0;
    cyc = 0;
    while (!busy && lat < 8) begin
      @(negedge clock);
      lat++;
    end
    pw0 = pixelWrite;
    while (busy && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  initial begin
    vec_t tbl[7];
    int   lat;
    int   cyc;
    bit   pw0;
    int   n;

    tbl[0] = '{0,   0,   16, 0,  16, 1};
    tbl[1] = '{10,  20,  16, 16, 32, 1};
    tbl[2] = '{238, 318, 4,  16, 32, 1};
    tbl[3] = '{0,   0,   16, 4,  32, 1};
    tbl[4] = '{239, 0,   4,  16, 32, 1};
    tbl[5] = '{250, 400, 0,  4,  32, 1};
    tbl[6] = '{236, 316, 16, 0,  32, 0};

    repeat (2) @(negedge clock);
    check("rst_pixelWrite", pixelWrite, 0);
    check("rst_xAddr", xAddr, 0);
    check("rst_yAddr", yAddr, 0);
    check("rst_pixelData", pixelData, 0);
    check("rst_busy", busy, 0);

    for (int i = 0; i < 7; i++) begin
      got_q.delete();
      exp_q.delete();
      model_move(tbl[i].x, tbl[i].y);
      @(negedge clock);
      xorigin = 8'(tbl[i].x);
      yorigin = 9'(tbl[i].y);
      if (i == 0) reset = 1'b1;
      wait_busy(lat, cyc, pw0);
      check($sformatf("v%0d_latency", i), lat, 1);
      check($sformatf("v%0d_first_write", i), pw0, tbl[i].pw0);
      check($sformatf("v%0d_busy_cycles", i), cyc, tbl[i].cyc);
      check($sformatf("v%0d_fg_writes", i), count_col(FG), tbl[i].fg);
      check($sformatf("v%0d_bg_writes", i), count_col(BG), tbl[i].bg);
      check_seq($sformatf("v%0d_sequence", i));
    end

    // Ready pattern 1-0-0-1 at the start of the draw phase.
    got_q.delete();
    exp_q.delete();
    model_move(50, 60);
    @(negedge clock);
    xorigin = 8'd50;
    yorigin = 9'd60;
    n = 0;
    while (!(busy && pixelWrite && pixelData == FG) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("stall_reach_draw", n < 100, 1);
    @(posedge clock);
    #1 pixelReady = 1'b0;
    @(negedge clock);
    check("stall_x", xAddr, 51);
    check("stall_y", yAddr, 60);
    check("stall_write", pixelWrite, 1);
    @(posedge clock);
    @(negedge clock);
    check("stall_x2", xAddr, 51);
    check("stall_write2", pixelWrite, 1);
    @(posedge clock);
    #1 pixelReady = 1'b1;
    @(negedge clock);
    check("stall_x3", xAddr, 51);
    wait_busy(lat, cyc, pw0);
    check("stall_done", cyc < 3000, 1);
    check("stall_fg_writes", count_col(FG), 16);
    check_seq("stall_sequence");

    // Origin moves during an erase are ignored until the move ends.
    got_q.delete();
    exp_q.delete();
    model_move(20, 30);
    model_move(7, 9);
    @(negedge clock);
    xorigin = 8'd20;
    yorigin = 9'd30;
    repeat (4) @(negedge clock);
    check("mid_busy", busy, 1);
    xorigin = 8'd5;
    yorigin = 9'd5;
    repeat (5) @(negedge clock);
    xorigin = 8'd7;
    yorigin = 9'd9;
    wait_busy(lat, cyc, pw0);
    check("mid_first_done", cyc < 3000, 1);
    wait_busy(lat, cyc, pw0);
    check("mid_second_latency", lat, 1);
    check("mid_second_cycles", cyc, 32);
    check_seq("mid_sequence");

    // Reset in the middle of a draw.
    got_q.delete();
    exp_q.delete();
    @(negedge clock);
    xorigin = 8'd100;
    yorigin = 9'd100;
    n = 0;
    while (!(busy && pixelData == FG) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("rstmid_reach_draw", n < 100, 1);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("rstmid_pixelWrite", pixelWrite, 0);
    check("rstmid_busy", busy, 0);
    got_q.delete();
    exp_q.delete();
    m_drawn = 0;
    model_move(100, 100);
    @(negedge clock);
    reset = 1'b1;
    wait_busy(lat, cyc, pw0);
    check("rstmid_latency", lat, 1);
    check("rstmid_cycles", cyc, 16);
    check_seq("rstmid_sequence");

    // Random origins with random pixelReady.
    rand_ready = 1;
    for (int i = 0; i < 12; i++) begin
      int x;
      int y;
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 511);
      if (i % 3 == 0) begin
        x = $urandom_range(232, 245);
        y = $urandom_range(312, 325);
      end
      if (x == m_x && y == m_y) x = (x + 1) % 256;
      got_q.delete();
      exp_q.delete();
      model_move(x, y);
      @(negedge clock);
      xorigin = 8'(x);
      yorigin = 9'(y);
      wait_busy(lat, cyc, pw0);
      check($sformatf("rnd%0d_latency", i), lat, 1);
      check($sformatf("rnd%0d_done", i), cyc < 3000, 1);
      check_seq($sformatf("rnd%0d_sequence", i));
    end
    rand_ready = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cursor_sprite_renderer.md
Name: cursor_sprite_renderer

Overview:
- Consumer of the cursor origin (xorigin/yorigin) produced by the key-driven pixel-position block. It is the reader side of that coordinate interface.
- On every origin change it erases the SIZE×SIZE cursor square at the old position with the background colour, then draws it at the new position with the foreground colour.
- Pixel writes go to the LT24 display driver via a valid/ready write port; panel is 240×320.

Parameters:
- SIZE, 4, cursor square edge in pixels (1..16).
- WIDTH, 240, panel columns; x valid range 0..WIDTH-1.
- HEIGHT, 320, panel rows; y valid range 0..HEIGHT-1.
- FG_COLOUR, 16'hFFFF, RGB565 cursor colour.
- BG_COLOUR, 16'h0000, RGB565 erase colour.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- xorigin  in  8  cursor x origin from the pixel-position block.
- yorigin  in  9  cursor y origin from the pixel-position block.
- pixelReady  in  1  LT24 driver can accept a write this cycle.
- pixelWrite  out  1  write request valid.
- xAddr  out  8  pixel x address.
- yAddr  out  9  pixel y address.
- pixelData  out  16  RGB565 pixel colour.
- busy  out  1  high while an erase/draw sequence is in progress.

Behaviour:
- Reset values: pixelWrite=0, xAddr=0, yAddr=0, pixelData=0, busy=0. Internal prev_x/prev_y=0, drawn=0, state=IDLE. Takes effect immediately, asynchronously.
- Transfer rule: a write completes on a clock edge where pixelWrite=1 and pixelReady=1. While pixelWrite=1 and pixelReady=0, xAddr/yAddr/pixelData stay stable and pixelWrite stays 1.
- pixelWrite decodes from registered state only; no combinational path from pixelReady.
- States:
  - IDLE: if drawn=0, latch tgt=(xorigin,yorigin) and go to DRAW. Else if (xorigin,yorigin)≠(prev_x,prev_y), latch tgt and go to ERASE. Else stay.
  - ERASE: scan SIZE×SIZE at (prev_x+col, prev_y+row), pixelData=BG_COLOUR. Go to DRAW after the last pixel.
  - DRAW: scan SIZE×SIZE at (tgt_x+col, tgt_y+row), pixelData=FG_COLOUR. After the last pixel: prev<=tgt, drawn<=1, go to IDLE.
- Scan order: col is the inner loop (0..SIZE-1), row the outer. Counters reset to 0 on entry to ERASE and DRAW.
- A pixel advances on transfer, or in one cycle with no write if it is clipped.
- Clipping: address sums are computed 1 bit wider. A pixel with x≥WIDTH or y≥HEIGHT is clipped: pixelWrite=0 for that pixel's cycle. No wrap-around.
- busy=1 in ERASE and DRAW, 0 in IDLE.
- Latency: origin change seen in IDLE at edge N gives first erase pixelWrite=1 in the cycle after edge N, unless that pixel is clipped.
- Origin changes during ERASE/DRAW are ignored. They are re-compared on return to IDLE; intermediate positions are never drawn.
- Simultaneous change of x and y is treated as one move.
- Reset mid-sequence: outputs drop at once. After release, drawn=0 forces a fresh DRAW at the current origin. The old partial square is not erased; this is accepted.
- Cycle count with pixelReady held high and no clipping: 2·SIZE² cycles per move, SIZE² for the initial draw.

Decomposition:
- Shared package lt24_pkg holds:
  - state encodings (IDLE/ERASE/DRAW, one-hot 3-bit);
  - LT24_WIDTH=240 and LT24_HEIGHT=320;
  - RGB565 colour constants;
  - coordinate widths (X_W=8, Y_W=9).
- One sub-module, sprite_scan_counter, contains:
  - col/row counters with clear and advance inputs;
  - base+offset address adders;
  - the clipped flag and the last-pixel flag.
- The top level holds the FSM, prev/tgt registers and the output mux.

Test Plan:
- Reset release with origin (0,0), pixelReady=1 → 16 FG writes at x0..3, y0..3 in row-major order; busy falls after 16 cycles; no BG writes.
- Origin moves to (10,20) → 16 BG writes covering (0..3,0..3), then 16 FG writes covering (10..13,20..23); busy high for exactly 32 cycles.
- pixelReady toggled 1-0-0-1 during DRAW → pixelWrite held with the same xAddr/yAddr/pixelData through the stall; no pixel duplicated or skipped; 16 total transfers.
- Origin (238,318) → only 4 FG writes, at (238..239,318..319); 12 clipped pixels take one cycle each with pixelWrite=0.
- Origin changes to (5,5) then (7,9) during an ERASE → sequence completes to the original target. Then one further erase/draw moves the cursor directly to (7,9); (5,5) is never drawn.
- reset driven to 0 mid-DRAW → pixelWrite and busy go 0 the same cycle. After release, 16 FG writes at the current origin.
